// File: rtl/i2c_codec_init.sv
// -----------------------------------------------------------------------------
// i2c_codec_init
//
// Purpose:
//   After a start pulse, writes a fixed table of nine 16-bit register words
//   to an audio codec over I2C. Each word becomes one write transaction:
//   START, DEV_ADDR, word[15:8], word[7:0], STOP. A NACK in any ACK slot
//   aborts the transaction; the same word is then retried from START. After
//   MAX_RETRY failed attempts the word is skipped and a sticky error is set.
//   The sequence always runs to completion. Only reset leaves DONE.
//
// Bit timing:
//   A tick occurs every CLK_DIV clocks. One SCL bit is four ticks, Q0..Q3:
//   Q0 SCL low and SDA changes, Q1/Q2 SCL high, Q3 SCL low. The ACK bit is
//   sampled on the Q2 tick.
//
// Ports:
//   i_clk       clock; all logic runs on its rising edge
//   i_rst       asynchronous active-high reset
//   i_start     single-cycle pulse that starts the sequence (IDLE only)
//   o_sclk      I2C SCL, push-pull
//   io_sdat     I2C SDA, open-drain (drives 0 or Z only)
//   o_busy      sequence in progress
//   o_finished  high from DONE entry until reset
//   o_ack_err   sticky: some word used up all of its retries
// -----------------------------------------------------------------------------
module i2c_codec_init #(
    parameter int unsigned CLK_DIV   = 125,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [7:0]  DEV_ADDR  = 8'h34
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_sclk,
    inout  wire  io_sdat,
    output logic o_busy,
    output logic o_finished,
    output logic o_ack_err
);

    localparam int unsigned TW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
    localparam logic [1:0] RETRY_LAST  = 2'(MAX_RETRY - 1);
    localparam logic [3:0] LAST_WORD   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        state_q;
    logic [1:0]    phase_q;
    logic [2:0]    bit_cnt_q;
    logic [1:0]    byte_cnt_q;
    logic [1:0]    retry_q;
    logic [3:0]    word_idx_q;
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          scl_q;
    logic          sda_oe_q;     // 1 = pull SDA low
    logic          nack_q;       // current attempt saw a NACK
    logic          busy_q;
    logic          finished_q;
    logic          ack_err_q;

    logic          tick;
    logic          sda_in;
    logic [15:0]   cur_word;
    logic [7:0]    cur_byte;

    function automatic logic [15:0] word_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    word_rom = 16'h1E00;
            4'd1:    word_rom = 16'h0097;
            4'd2:    word_rom = 16'h0297;
            4'd3:    word_rom = 16'h0815;
            4'd4:    word_rom = 16'h0A00;
            4'd5:    word_rom = 16'h0C00;
            4'd6:    word_rom = 16'h0E42;
            4'd7:    word_rom = 16'h1019;
            4'd8:    word_rom = 16'h1201;
            default: word_rom = 16'h0000;
        endcase
    endfunction

    // Open-drain SDA: only ever pull low or release.
    assign io_sdat = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in  = io_sdat;

    assign o_sclk     = scl_q;
    assign o_busy     = busy_q;
    assign o_finished = finished_q;
    assign o_ack_err  = ack_err_q;

    assign tick = (tick_cnt_q == TICK_MAX);

    always_comb begin
        cur_word = word_rom(word_idx_q);
        case (byte_cnt_q)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = cur_word[15:8];
            default: cur_byte = cur_word[7:0];
        endcase
    end

    // The divider is held at 0 while idle so the first tick of a sequence
    // lands a full CLK_DIV cycles after the start pulse is accepted.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (state_q == S_IDLE || state_q == S_DONE || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Main sequencer. Every active state spends four ticks per step; phase_q
    // names the quarter whose action is applied on the next tick, and all
    // state changes happen on the Q3 tick so the next step starts at Q0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 2'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            retry_q    <= 2'd0;
            word_idx_q <= 4'd0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                    if (i_start) begin
                        state_q    <= S_START;
                        phase_q    <= 2'd0;
                        word_idx_q <= 4'd0;
                        retry_q    <= 2'd0;
                        busy_q     <= 1'b1;
                    end
                end

                // SDA falls on Q1 while SCL is high, SCL falls on Q3.
                S_START: if (tick) begin
                    phase_q <= phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_q    <= 1'b1;
                            sda_oe_q <= 1'b0;
                        end
                        2'd1: sda_oe_q <= 1'b1;
                        2'd3: begin
                            scl_q      <= 1'b0;
                            bit_cnt_q  <= 3'd0;
                            byte_cnt_q <= 2'd0;
                            state_q    <= S_DATA;
                        end
                        default: ;
                    endcase
                end

                S_DATA: if (tick) begin
                    phase_q <= phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_q    <= 1'b0;
                            sda_oe_q <= ~cur_byte[3'd7 - bit_cnt_q];
                        end
                        2'd1: scl_q <= 1'b1;
                        2'd3: begin
                            scl_q <= 1'b0;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= 3'd0;
                                state_q   <= S_ACK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end

                S_ACK: if (tick) begin
                    phase_q <= phase_q + 2'd1;
                    case (phase_q)
                        2'd0: sda_oe_q <= 1'b0;
                        2'd1: scl_q    <= 1'b1;
                        2'd2: nack_q   <= sda_in;
                        default: begin
                            scl_q <= 1'b0;
                            // A NACK on any byte abandons the rest of the word.
                            if (nack_q || byte_cnt_q == 2'd2) begin
                                state_q <= S_STOP;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                state_q    <= S_DATA;
                            end
                        end
                    endcase
                end

                // SDA low with SCL low, SCL rises, then SDA rises.
                S_STOP: if (tick) begin
                    phase_q <= phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_q    <= 1'b0;
                            sda_oe_q <= 1'b1;
                        end
                        2'd1: scl_q    <= 1'b1;
                        2'd2: sda_oe_q <= 1'b0;
                        default: state_q <= S_GAP;
                    endcase
                end

                // Bus idle for one bit time, then retry, move on, or finish.
                S_GAP: if (tick) begin
                    phase_q  <= phase_q + 2'd1;
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                    if (phase_q == 2'd3) begin
                        nack_q <= 1'b0;
                        if (nack_q && retry_q != RETRY_LAST) begin
                            retry_q <= retry_q + 2'd1;
                            state_q <= S_START;
                        end else begin
                            if (nack_q) begin
                                ack_err_q <= 1'b1;
                            end
                            retry_q <= 2'd0;
                            if (word_idx_q == LAST_WORD) begin
                                state_q    <= S_DONE;
                                busy_q     <= 1'b0;
                                finished_q <= 1'b1;
                            end else begin
                                word_idx_q <= word_idx_q + 4'd1;
                                state_q    <= S_START;
                            end
                        end
                    end
                end

                S_DONE: begin
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
